// File: rtl/arp_pkg.sv
// Shared ARP constants, frame geometry, queue entry type and FSM state encodings
// for the ARP responder and its reply queue.
package arp_pkg;

    localparam logic [15:0] ARP_ETHERTYPE = 16'h0806;
    localparam logic [15:0] ARP_HTYPE     = 16'h0001;
    localparam logic [15:0] ARP_PTYPE     = 16'h0800;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;
    localparam logic [15:0] OPER_REQ      = 16'h0001;
    localparam logic [15:0] OPER_REPLY    = 16'h0002;

    localparam int RX_LEN = 28;
    localparam int TX_LEN = 30;

    localparam logic [4:0] OFF_SHA = 5'd8;
    localparam logic [4:0] OFF_SPA = 5'd14;
    localparam logic [4:0] OFF_THA = 5'd18;
    localparam logic [4:0] OFF_TPA = 5'd24;
    localparam logic [4:0] RX_LAST = 5'(RX_LEN - 1);
    localparam logic [4:0] TX_LAST = 5'(TX_LEN - 1);

    localparam int SLOT_MAX_W = 2;

    typedef struct packed {
        logic [47:0]           mac;
        logic [31:0]           ip;
        logic [SLOT_MAX_W-1:0] slot;
    } arp_entry_t;

    typedef enum logic [1:0] {R_IDLE, R_RX, R_SKIP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_SEND} tx_state_t;

    // Expected value of request header byte idx (0..7).
    function automatic logic [7:0] rx_header_byte(input logic [2:0] idx);
        logic [63:0] hdr;
        hdr = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, OPER_REQ};
        return hdr[{~idx, 3'b000} +: 8];
    endfunction

    // First ten transmitted bytes: ethertype followed by the fixed ARP header.
    function automatic logic [79:0] tx_header(input logic [15:0] oper);
        return {ARP_ETHERTYPE, ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, oper};
    endfunction

endpackage

// File: rtl/arp_reply_fifo.sv
// Small first-word-fall-through queue of pending ARP replies; a push into a full
// queue is still accepted when a pop happens in the same cycle.
module arp_reply_fifo
    import arp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  arp_entry_t push_data,
    input  logic       pop,
    output arp_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arp_entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == (PTR_W+1)'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        head = mem[rd_ptr_q];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/arp_responder_mc.sv
// ARP engine: parses requests from the RX byte stream, queues replies for local
// IP slots, and transmits replies and gratuitous announcements on grant.
module arp_responder_mc
    import arp_pkg::*;
#(
    parameter int NUM_IP      = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_enable,
    input  logic [7:0]           rx_data,
    input  logic [47:0]          local_mac,
    input  logic [NUM_IP*32-1:0] local_ip,
    input  logic [NUM_IP-1:0]    ip_valid,
    input  logic                 announce,
    input  logic                 tx_enable,
    output logic                 tx_request,
    output logic [7:0]           tx_data,
    output logic                 tx_active,
    output logic [47:0]          destination_mac,
    output logic [7:0]           rx_drop_count
);

    localparam int SLOT_W = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;

    rx_state_t         rx_state_q, rx_state_d;
    logic [4:0]        rx_cnt_q, rx_cnt_d;
    logic [47:0]       sha_q, sha_d;
    logic [31:0]       spa_q, spa_d;
    logic [23:0]       tpa_q, tpa_d;
    logic [7:0]        drop_q, drop_d;

    tx_state_t         tx_state_q, tx_state_d;
    logic [4:0]        tx_cnt_q, tx_cnt_d;
    logic [239:0]      frame_q, frame_d;
    logic [47:0]       dest_q, dest_d;
    logic              src_ann_q, src_ann_d;
    logic [SLOT_W-1:0] ann_slot_q, ann_slot_d;
    logic [NUM_IP-1:0] pend_q, pend_d;

    logic [31:0]       ip_slot [NUM_IP];
    logic [NUM_IP-1:0] match_vec;
    logic [SLOT_W-1:0] match_slot, ann_pick;
    logic [31:0]       reply_ip, ann_ip;
    logic [NUM_IP-1:0] ann_clear;
    logic [4:0]        tx_byte_idx;
    logic              commit;
    arp_entry_t        push_entry, fifo_head;
    logic              fifo_pop, fifo_full, fifo_empty;

    for (genvar gi = 0; gi < NUM_IP; gi++) begin : g_slot
        assign ip_slot[gi]   = local_ip[gi*32 +: 32];
        assign match_vec[gi] = ip_valid[gi] && (ip_slot[gi] == {tpa_q, rx_data});
    end

    // Lowest-index priority for both target-IP matches and pending announces.
    always_comb begin
        match_slot = '0;
        ann_pick   = '0;
        for (int k = NUM_IP - 1; k >= 0; k--) begin
            if (match_vec[k]) match_slot = SLOT_W'(k);
            if (pend_q[k])    ann_pick   = SLOT_W'(k);
        end
        reply_ip = ip_slot[0];
        ann_ip   = ip_slot[0];
        for (int k = 0; k < NUM_IP; k++) begin
            if (fifo_head.slot == SLOT_MAX_W'(k)) reply_ip = ip_slot[k];
            if (ann_pick == SLOT_W'(k))           ann_ip   = ip_slot[k];
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tpa_d      = tpa_q;
        commit     = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_enable) begin
                    rx_cnt_d   = 5'd1;
                    rx_state_d = (rx_data == rx_header_byte(3'd0)) ? R_RX : R_SKIP;
                end
            end
            R_RX: begin
                if (!rx_enable) begin
                    rx_state_d = R_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_cnt_q < OFF_SHA) begin
                        if (rx_data != rx_header_byte(rx_cnt_q[2:0])) rx_state_d = R_SKIP;
                    end else if (rx_cnt_q < OFF_SPA) begin
                        sha_d = {sha_q[39:0], rx_data};
                    end else if (rx_cnt_q < OFF_THA) begin
                        spa_d = {spa_q[23:0], rx_data};
                    end else if (rx_cnt_q == RX_LAST) begin
                        rx_state_d = R_SKIP;
                        commit     = |match_vec;
                    end else if (rx_cnt_q >= OFF_TPA) begin
                        tpa_d = {tpa_q[15:0], rx_data};
                    end
                end
            end
            R_SKIP: begin
                if (!rx_enable) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase

        push_entry.mac  = sha_q;
        push_entry.ip   = spa_q;
        push_entry.slot = SLOT_MAX_W'(match_slot);

        // A full queue still takes the push when the transmitter pops this cycle.
        drop_d = drop_q;
        if (commit && fifo_full && !fifo_pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        frame_d    = frame_q;
        dest_d     = dest_q;
        src_ann_d  = src_ann_q;
        ann_slot_d = ann_slot_q;
        fifo_pop   = 1'b0;
        ann_clear  = '0;
        case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    frame_d    = {tx_header(OPER_REPLY), local_mac, reply_ip,
                                  fifo_head.mac, fifo_head.ip};
                    dest_d     = fifo_head.mac;
                    src_ann_d  = 1'b0;
                    tx_state_d = T_REQ;
                end else if (|pend_q) begin
                    frame_d    = {tx_header(OPER_REQ), local_mac, ann_ip, 48'h0, ann_ip};
                    dest_d     = '1;
                    src_ann_d  = 1'b1;
                    ann_slot_d = ann_pick;
                    tx_state_d = T_REQ;
                end
            end
            T_REQ: begin
                if (tx_enable) begin
                    tx_cnt_d   = 5'd1;
                    tx_state_d = T_SEND;
                end
            end
            T_SEND: begin
                if (tx_cnt_q == TX_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = T_IDLE;
                    fifo_pop   = !src_ann_q;
                    for (int k = 0; k < NUM_IP; k++) begin
                        ann_clear[k] = src_ann_q && (ann_slot_q == SLOT_W'(k));
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 5'd1;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase

        pend_d = (pend_q & ~ann_clear) | (announce ? ip_valid : '0);
    end

    // Outputs derive from reset flops so an abandoned frame goes quiet immediately.
    always_comb begin
        tx_request      = (tx_state_q == T_REQ);
        tx_active       = ((tx_state_q == T_REQ) && tx_enable) || (tx_state_q == T_SEND);
        tx_byte_idx     = TX_LAST - tx_cnt_q;
        tx_data         = tx_active ? frame_q[{tx_byte_idx, 3'b000} +: 8] : 8'h00;
        destination_mac = dest_q;
        rx_drop_count   = drop_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            sha_q      <= '0;
            spa_q      <= '0;
            tpa_q      <= '0;
            drop_q     <= '0;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            frame_q    <= '0;
            dest_q     <= '0;
            src_ann_q  <= 1'b0;
            ann_slot_q <= '0;
            pend_q     <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            tpa_q      <= tpa_d;
            drop_q     <= drop_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            frame_q    <= frame_d;
            dest_q     <= dest_d;
            src_ann_q  <= src_ann_d;
            ann_slot_q <= ann_slot_d;
            pend_q     <= pend_d;
        end
    end

    arp_reply_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (commit),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule
